sa_tile_array: RTL and testbench
================================

# sa_tile_array

Parametrised output-stationary systolic array, successor to the fixed 16×16 SA_out array in the accelerator datapath. Accepts one unskewed data vector and one weight vector per beat, applies row/column skew internally and accumulates an N×N tile of dot products in place. After the last beat, a drain FSM streams the accumulators out one row per beat over a valid/ready handshake. Adds configurable size, signed/saturating modes, bubble tolerance and per-row masking.

## Interface
- N, 16: rows = columns = vector lanes
- DW, 8: data/weight element width
- AW, 32: accumulator width (AW ≥ 2·DW)
- SIGNED, 0: 1 = two's-complement operands, 0 = unsigned
- SAT, 0: 1 = saturating accumulate, 0 = modulo-2^AW wrap

- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- SA_fire_in  in  1  input beat valid
- SA_last_in  in  1  marks last beat of tile (qualified by fire)
- SA_data_in  in  N·DW  lane i → array row i
- SA_weight_in  in  N·DW  lane j → array column j
- CEN  in  N  per-row disable, active high, sampled with each beat
- SA_ready  out  1  beat accepted when SA_fire_in & SA_ready
- SA_busy  out  1  state ≠ IDLE
- Q_valid  out  1  drain row valid
- Q_ready  in  1  consumer accepts row
- Q_row  out  clog2(N)  index of row on Q
- Q  out  N·AW  lane j = accumulator (Q_row, j)

## Operation
- FSM: IDLE → COMPUTE → FLUSH → DRAIN → IDLE.
- IDLE: SA_ready=1. First accepted beat clears all N² accumulators on that edge and enters COMPUTE. If that beat also carries last, go directly to FLUSH.
- COMPUTE: SA_ready=1. Beats with fire=0 are bubbles: a valid bit travels with each operand, and PEs ignore invalid operands. Accepted beat with last=1 → FLUSH.
- FLUSH: SA_ready=0. Counter runs 2N-1 cycles, then → DRAIN with Q_row=0.
- DRAIN: SA_ready=0, Q_valid=1. On Q_valid & Q_ready: Q_row increments. After row N-1 is accepted → IDLE.
- Skew: data lane i delayed i cycles, weight lane j delayed j cycles. Data moves right and weight moves down one PE per cycle.
- CEN[i]=1 on a beat: row i skips that beat's contribution and holds its accumulators. Other rows are unaffected.
- Arithmetic: product is 2·DW bits, sign- or zero-extended to AW, then added to the accumulator.
  - SAT=0: wraps modulo 2^AW.
  - SAT=1, signed: clamps to [-2^(AW-1), 2^(AW-1)-1].
  - SAT=1, unsigned: clamps to 2^AW-1.
- SA_last_in without fire is ignored. Fire outside IDLE/COMPUTE is ignored (no state change).

## Timing
- Reset (async, any state): state=IDLE; accumulators, skew registers, valid bits and counters cleared. Outputs: SA_ready=1, SA_busy=0, Q_valid=0, Q_row=0, Q=0.
- Reset mid-COMPUTE, FLUSH or DRAIN aborts the tile with no output. The next accepted beat starts a fresh tile.
- Beat accepted at edge t reaches PE(i,j) and is accumulated at edge t+1+i+j.
- Last beat accepted at edge t_L: Q_valid first high after edge t_L+2N, with all accumulators final.
- Q and Q_row are held stable while Q_valid & !Q_ready. Minimum drain time is N cycles.
- Back-to-back tiles: the next beat can be accepted the cycle after the final Q handshake, once SA_ready=1.
- Minimum tile period: K + 2N-1 + N cycles plus the IDLE cycle, where K is the number of beats.

## Test plan
- Reset: drive rst_n low mid-cycle with inputs toggling → all outputs hold reset values, SA_ready=1. Release, then send a 1-beat tile → normal result.
- N=4, single beat data=all 2, weight=all 3, last=1 → Q_valid rises 8 cycles later. Rows 0..3 each read 6 in every lane, Q_row steps 0→3 with Q_ready=1.
- N=16, 16 beats, data lane i = k+1 at beat k, weight = all 1 → every accumulator reads 136. With a 3-cycle fire=0 bubble inserted mid-tile → still 136.
- Same tile with CEN[2]=1 on beat k=15 → row 2 reads 120 in every lane; other rows read 136.
- Backpressure: Q_ready low 5 cycles on row 1 → Q and Q_row unchanged throughout. Fire asserted during DRAIN → ignored, next tile result unaffected.
- SIGNED=1, AW=16, 3 beats of data = -128, weight = -128 → SAT=1 reads 32767, SAT=0 reads -16384. Reset asserted during FLUSH → Q_valid never rises, state returns to IDLE.

Source files
------------

// File: rtl/sa_tile_array.sv
// ---------------------------------------------------------------------------
// sa_tile_array
//
// Parametrised output-stationary systolic array. Each accepted beat delivers
// one unskewed data vector (lane i feeds row i) and one weight vector
// (lane j feeds column j). The array skews them internally and accumulates
// an N x N tile of dot products in place. After the last beat, a flush
// period lets the wavefront reach PE(N-1,N-1). The tile is then drained one
// row per beat over a valid/ready handshake.
//
// Parameters
//   N      rows = columns = vector lanes
//   DW     data/weight element width
//   AW     accumulator width (AW >= 2*DW)
//   SIGNED 1 = two's-complement operands, 0 = unsigned
//   SAT    1 = saturating accumulate, 0 = modulo-2^AW wrap
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   SA_fire_in      input beat valid
//   SA_last_in      last beat of the tile (qualified by fire)
//   SA_data_in      N lanes of DW, lane i -> row i
//   SA_weight_in    N lanes of DW, lane j -> column j
//   CEN             per-row skip of the current beat
//   SA_ready        beat accepted when SA_fire_in & SA_ready
//   SA_busy         a tile is in progress
//   Q_valid/Q_ready drain handshake
//   Q_row           index of the row presented on Q
//   Q               N lanes of AW, lane j = accumulator (Q_row, j)
// ---------------------------------------------------------------------------
module sa_tile_array #(
   parameter int N      = 16,
   parameter int DW     = 8,
   parameter int AW     = 32,
   parameter int SIGNED = 0,
   parameter int SAT    = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 SA_fire_in,
   input  logic                 SA_last_in,
   input  logic [N*DW-1:0]      SA_data_in,
   input  logic [N*DW-1:0]      SA_weight_in,
   input  logic [N-1:0]         CEN,
   output logic                 SA_ready,
   output logic                 SA_busy,
   output logic                 Q_valid,
   input  logic                 Q_ready,
   output logic [$clog2(N)-1:0] Q_row,
   output logic [N*AW-1:0]      Q
);

   localparam int RW = $clog2(N);
   localparam int CW = $clog2(2*N) + 1;
   localparam logic [CW-1:0] FLUSH_LAST = CW'(2*N-1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(N-1);

   typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [RW-1:0]  row_q, row_d;
   logic           accept;
   logic           clearAcc;

   // Operand fabric: aOp/bOp are the operands seen by PE(i,j) this cycle,
   // each tagged with a valid bit so bubbles and masked rows are ignored.
   logic [DW-1:0]  aOp    [N][N];
   logic           aOpV   [N][N];
   logic [DW-1:0]  bOp    [N][N];
   logic           bOpV   [N][N];
   logic [AW-1:0]  accAll [N][N];

   assign accept   = SA_fire_in & SA_ready;
   assign clearAcc = accept & (state_q == IDLE);
   assign SA_busy  = (state_q != IDLE);
   assign Q_row    = row_q;

   // One multiply-accumulate step: extend the 2*DW product to AW, add, and
   // either wrap or clamp depending on SAT/SIGNED.
   function automatic logic [AW-1:0] macStep(input logic [AW-1:0] acc,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      logic [2*DW-1:0] ax;
      logic [2*DW-1:0] bx;
      logic [2*DW-1:0] prod;
      logic [AW-1:0]   ext;
      logic [AW:0]     sum;
      logic [AW-1:0]   res;
      ax   = (SIGNED != 0) ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
      bx   = (SIGNED != 0) ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
      prod = ax * bx;
      ext  = ((SIGNED != 0) && prod[2*DW-1]) ? '1 : '0;
      ext[2*DW-1:0] = prod;
      sum  = {1'b0, acc} + {1'b0, ext};
      res  = sum[AW-1:0];
      if (SAT != 0) begin
         if (SIGNED != 0) begin
            if ((acc[AW-1] == ext[AW-1]) && (sum[AW-1] != acc[AW-1]))
               res = acc[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
         end else if (sum[AW]) begin
            res = '1;
         end
      end
      return res;
   endfunction

   // State, flush counter and drain row index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
      end
   end

   // Next-state and handshake outputs. The flush counter runs 2N-1 cycles so
   // the last beat has reached the far corner PE before draining starts.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      row_d    = row_q;
      SA_ready = 1'b0;
      Q_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            SA_ready = 1'b1;
            if (SA_fire_in) begin
               state_d = SA_last_in ? FLUSH : COMPUTE;
               cnt_d   = '0;
            end
         end
         COMPUTE: begin
            SA_ready = 1'b1;
            if (SA_fire_in && SA_last_in) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end
         end
         FLUSH: begin
            if (cnt_q == FLUSH_LAST) begin
               state_d = DRAIN;
               row_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DRAIN: begin
            Q_valid = 1'b1;
            if (Q_ready) begin
               if (row_q == ROW_LAST) begin
                  state_d = IDLE;
                  row_d   = '0;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Row skew: data lane i passes through i+1 registers before entering
   // PE(i,0). CEN clears the valid bit so the whole row skips this beat.
   for (genvar i = 0; i < N; i++) begin : gDataSkew
      logic [DW-1:0] line_q [i+1];
      logic          vld_q  [i+1];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k <= i; k++) begin
               line_q[k] <= '0;
               vld_q[k]  <= 1'b0;
            end
         end else begin
            line_q[0] <= SA_data_in[i*DW +: DW];
            vld_q[0]  <= accept & ~CEN[i];
            for (int k = 1; k <= i; k++) begin
               line_q[k] <= line_q[k-1];
               vld_q[k]  <= vld_q[k-1];
            end
         end
      end
      assign aOp[i][0]  = line_q[i];
      assign aOpV[i][0] = vld_q[i];
   end

   // Column skew: weight lane j passes through j+1 registers before
   // entering PE(0,j).
   for (genvar j = 0; j < N; j++) begin : gWeightSkew
      logic [DW-1:0] line_q [j+1];
      logic          vld_q  [j+1];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k <= j; k++) begin
               line_q[k] <= '0;
               vld_q[k]  <= 1'b0;
            end
         end else begin
            line_q[0] <= SA_weight_in[j*DW +: DW];
            vld_q[0]  <= accept;
            for (int k = 1; k <= j; k++) begin
               line_q[k] <= line_q[k-1];
               vld_q[k]  <= vld_q[k-1];
            end
         end
      end
      assign bOp[0][j]  = line_q[j];
      assign bOpV[0][j] = vld_q[j];
   end

   // PE grid: each PE accumulates when both operands are valid and forwards
   // data to the right and weights downward one hop per cycle.
   for (genvar i = 0; i < N; i++) begin : gRow
      for (genvar j = 0; j < N; j++) begin : gCol
         logic [AW-1:0] acc_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               acc_q <= '0;
            else if (clearAcc)
               acc_q <= '0;
            else if (aOpV[i][j] && bOpV[i][j])
               acc_q <= macStep(acc_q, aOp[i][j], bOp[i][j]);
         end
         assign accAll[i][j] = acc_q;

         if (j < N-1) begin : gPassA
            logic [DW-1:0] a_q;
            logic          av_q;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  a_q  <= '0;
                  av_q <= 1'b0;
               end else begin
                  a_q  <= aOp[i][j];
                  av_q <= aOpV[i][j];
               end
            end
            assign aOp[i][j+1]  = a_q;
            assign aOpV[i][j+1] = av_q;
         end

         if (i < N-1) begin : gPassB
            logic [DW-1:0] b_q;
            logic          bv_q;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  b_q  <= '0;
                  bv_q <= 1'b0;
               end else begin
                  b_q  <= bOp[i][j];
                  bv_q <= bOpV[i][j];
               end
            end
            assign bOp[i+1][j]  = b_q;
            assign bOpV[i+1][j] = bv_q;
         end
      end
   end

   // Drain mux: present the selected accumulator row on Q.
   always_comb begin
      Q = '0;
      for (int j = 0; j < N; j++)
         Q[j*AW +: AW] = accAll[row_q][j];
   end

endmodule

// File: tb/tb_sa_tile_array.sv
// ---------------------------------------------------------------------------
// tb_sa_tile_array
//
// Four instances share one stimulus stream:
//   dutA  N=16, unsigned, wrap, AW=32
//   dutS  N=16, signed, saturating, AW=16
//   dutW  N=16, signed, wrap, AW=16
//   dutD  N=4,  unsigned, wrap, AW=32 (fed from the low four lanes)
// Stimulus pushes hand-computed rows into per-instance queues; independent
// monitors pop and compare on every drain handshake.
// ---------------------------------------------------------------------------
module tb_sa_tile_array;

   localparam int N   = 16;
   localparam int ND  = 4;
   localparam int DW  = 8;
   localparam int AWL = 32;
   localparam int AWS = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic fire, last, qReady, maskD, fireD;
   logic [N*DW-1:0] dataIn, weightIn;
   logic [N-1:0]    cen;

   logic readyA, busyA, validA; logic [3:0] rowA; logic [N*AWL-1:0]  qA;
   logic readyS, busyS, validS; logic [3:0] rowS; logic [N*AWS-1:0]  qS;
   logic readyW, busyW, validW; logic [3:0] rowW; logic [N*AWS-1:0]  qW;
   logic readyD, busyD, validD; logic [1:0] rowD; logic [ND*AWL-1:0] qD;

   typedef struct { int row; longint val; } exp_t;
   exp_t expA[$], expS[$], expW[$], expD[$];
   exp_t eA, eS, eW, eD;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   // The small array can be kept out of the shared stream while the large
   // arrays are probed with beats that must be ignored.
   assign fireD = fire & ~maskD;

   sa_tile_array #(.N(N), .DW(DW), .AW(AWL), .SIGNED(0), .SAT(0)) dutA (
      .clk(clk), .rst_n(rst_n), .SA_fire_in(fire), .SA_last_in(last),
      .SA_data_in(dataIn), .SA_weight_in(weightIn), .CEN(cen),
      .SA_ready(readyA), .SA_busy(busyA), .Q_valid(validA), .Q_ready(qReady),
      .Q_row(rowA), .Q(qA));

   sa_tile_array #(.N(N), .DW(DW), .AW(AWS), .SIGNED(1), .SAT(1)) dutS (
      .clk(clk), .rst_n(rst_n), .SA_fire_in(fire), .SA_last_in(last),
      .SA_data_in(dataIn), .SA_weight_in(weightIn), .CEN(cen),
      .SA_ready(readyS), .SA_busy(busyS), .Q_valid(validS), .Q_ready(qReady),
      .Q_row(rowS), .Q(qS));

   sa_tile_array #(.N(N), .DW(DW), .AW(AWS), .SIGNED(1), .SAT(0)) dutW (
      .clk(clk), .rst_n(rst_n), .SA_fire_in(fire), .SA_last_in(last),
      .SA_data_in(dataIn), .SA_weight_in(weightIn), .CEN(cen),
      .SA_ready(readyW), .SA_busy(busyW), .Q_valid(validW), .Q_ready(qReady),
      .Q_row(rowW), .Q(qW));

   sa_tile_array #(.N(ND), .DW(DW), .AW(AWL), .SIGNED(0), .SAT(0)) dutD (
      .clk(clk), .rst_n(rst_n), .SA_fire_in(fireD), .SA_last_in(last),
      .SA_data_in(dataIn[ND*DW-1:0]), .SA_weight_in(weightIn[ND*DW-1:0]),
      .CEN(cen[ND-1:0]),
      .SA_ready(readyD), .SA_busy(busyD), .Q_valid(validD), .Q_ready(qReady),
      .Q_row(rowD), .Q(qD));

   // Replicate one expected accumulator value across every lane of a row.
   function automatic logic [511:0] buildRow(input longint v, input int lanes, input int aw);
      logic [511:0] r;
      r = '0;
      for (int j = 0; j < lanes; j++)
         for (int b = 0; b < aw; b++)
            r[j*aw + b] = v[b];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic reportSpurious(input string name, input int row);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: drain row %0d presented, required none outstanding", name, row);
   endtask

   // Queue one expected tile per instance; cenRow (if >= 0) loses dec.
   task automatic pushTile(input longint vA, input longint vS, input longint vW,
                           input longint vD, input int cenRow, input longint dec);
      for (int r = 0; r < N; r++) begin
         longint d;
         d = (r == cenRow) ? dec : 64'sd0;
         expA.push_back('{r, vA - d});
         expS.push_back('{r, vS - d});
         expW.push_back('{r, vW - d});
         if (r < ND) expD.push_back('{r, vD - d});
      end
   endtask

   // Drive one beat just after a rising edge; the next edge samples it.
   task automatic applyStimulus(input logic f, input logic l, input logic [N*DW-1:0] d,
                                input logic [N*DW-1:0] w, input logic [N-1:0] c);
      @(posedge clk);
      #1;
      fire = f; last = l; dataIn = d; weightIn = w; cen = c;
   endtask

   task automatic tileConst(input logic [7:0] dv, input logic [7:0] wv, input int beats);
      for (int k = 0; k < beats; k++)
         applyStimulus(1'b1, k == beats-1, {N{dv}}, {N{wv}}, '0);
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
   endtask

   // 16 beats, every data lane = k+1 at beat k, weights all 1.
   task automatic tileRamp(input bit bubble, input bit cenOn);
      for (int k = 0; k < 16; k++) begin
         if (bubble && k == 8)
            for (int b = 0; b < 3; b++)
               applyStimulus(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom},
                             {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
         applyStimulus(1'b1, k == 15, {N{8'(k+1)}}, {N{8'd1}},
                       (cenOn && k == 15) ? 16'h0004 : 16'h0000);
      end
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic waitAllIdle(input string name);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (!busyA && !busyS && !busyW && !busyD &&
             expA.size() == 0 && expS.size() == 0 && expW.size() == 0 && expD.size() == 0)
            done = 1'b1;
      end
      checkOutput({name, "_idle"}, done, 1);
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, "_readyA"}, readyA, 1);
      checkOutput({name, "_busyA"},  busyA, 0);
      checkOutput({name, "_validA"}, validA, 0);
      checkOutput({name, "_rowA"},   rowA, 0);
      checkOutput({name, "_qA"},     qA, 0);
      checkOutput({name, "_qS"},     qS, 0);
      checkOutput({name, "_readyD"}, readyD, 1);
      checkOutput({name, "_busyD"},  busyD, 0);
      checkOutput({name, "_validD"}, validD, 0);
      checkOutput({name, "_qD"},     qD, 0);
   endtask

   // Monitors: one per instance, popping on each drain handshake.
   always @(negedge clk) begin
      if (rst_n && validA && qReady) begin
         if (expA.size() == 0) reportSpurious("A_spurious", int'(rowA));
         else begin
            eA = expA.pop_front();
            checkOutput("A_row", rowA, eA.row);
            checkOutput("A_q", qA, buildRow(eA.val, N, AWL));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && validS && qReady) begin
         if (expS.size() == 0) reportSpurious("S_spurious", int'(rowS));
         else begin
            eS = expS.pop_front();
            checkOutput("S_row", rowS, eS.row);
            checkOutput("S_q", qS, buildRow(eS.val, N, AWS));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && validW && qReady) begin
         if (expW.size() == 0) reportSpurious("W_spurious", int'(rowW));
         else begin
            eW = expW.pop_front();
            checkOutput("W_row", rowW, eW.row);
            checkOutput("W_q", qW, buildRow(eW.val, N, AWS));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && validD && qReady) begin
         if (expD.size() == 0) reportSpurious("D_spurious", int'(rowD));
         else begin
            eD = expD.pop_front();
            checkOutput("D_row", rowD, eD.row);
            checkOutput("D_q", qD, buildRow(eD.val, ND, AWL));
         end
      end
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit found;
      bit sawValid;
      rst_n = 1'b0; fire = 1'b0; last = 1'b0; dataIn = '0; weightIn = '0;
      cen = '0; qReady = 1'b1; maskD = 1'b0;
      #1;
      checkResetOutputs("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-COMPUTE with inputs toggling.
      applyStimulus(1'b1, 1'b0, {N{8'd5}}, {N{8'd7}}, '0);
      applyStimulus(1'b1, 1'b0, {N{8'd5}}, {N{8'd7}}, '0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("rstMid");
      for (int t = 0; t < 3; t++) begin
         #3;
         fire = 1'($urandom); last = 1'($urandom); cen = 16'($urandom);
         dataIn = {$urandom, $urandom, $urandom, $urandom};
         weightIn = {$urandom, $urandom, $urandom, $urandom};
         #1;
         checkResetOutputs("rstHold");
      end
      fire = 1'b0; last = 1'b0; cen = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Single beat 2 x 3, with first-valid latency checks.
      pushTile(6, 6, 6, 6, -1, 0);
      tileConst(8'd2, 8'd3, 1);
      @(negedge clk);
      for (int k = 1; k <= 2*N; k++) begin
         @(negedge clk);
         if (k == 2*ND-1) checkOutput("D_validEarly", validD, 0);
         if (k == 2*ND)   checkOutput("D_validOnTime", validD, 1);
         if (k == 2*N-1)  checkOutput("A_validEarly", validA, 0);
         if (k == 2*N)    checkOutput("A_validOnTime", validA, 1);
      end
      waitAllIdle("single");

      // 16-beat ramp, without and with a bubble, then with CEN on row 2.
      pushTile(136, 136, 136, 136, -1, 0);
      tileRamp(1'b0, 1'b0);
      waitAllIdle("ramp");
      pushTile(136, 136, 136, 136, -1, 0);
      tileRamp(1'b1, 1'b0);
      waitAllIdle("bubble");
      pushTile(136, 136, 136, 136, 2, 16);
      tileRamp(1'b0, 1'b1);
      waitAllIdle("cen");

      // Backpressure on row 1, with fire asserted during DRAIN.
      pushTile(6, 6, 6, 6, -1, 0);
      tileConst(8'd2, 8'd3, 1);
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(posedge clk);
         #1;
         if (validA && rowA == 4'd1) found = 1'b1;
      end
      checkOutput("bp_reachRow1", found, 1);
      qReady = 1'b0; maskD = 1'b1; fire = 1'b1; last = 1'b1;
      dataIn = {N{8'hFF}}; weightIn = {N{8'hFF}};
      repeat (5) begin
         @(negedge clk);
         checkOutput("bp_row", rowA, 1);
         checkOutput("bp_q", qA, buildRow(6, N, AWL));
         checkOutput("bp_valid", validA, 1);
         checkOutput("bp_ready", readyA, 0);
      end
      @(posedge clk);
      #1;
      qReady = 1'b1; fire = 1'b0; last = 1'b0; maskD = 1'b0;
      dataIn = '0; weightIn = '0;
      waitAllIdle("bp");

      // Signed -128 x -128, three beats: saturating vs wrapping.
      pushTile(49152, 32767, -16384, 49152, -1, 0);
      tileConst(8'h80, 8'h80, 3);
      waitAllIdle("signed");

      // Reset during FLUSH aborts the tile with no output.
      tileConst(8'd1, 8'd1, 1);
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busyA", busyA, 0);
      checkOutput("abort_busyD", busyD, 0);
      checkOutput("abort_readyA", readyA, 1);
      @(negedge clk);
      rst_n = 1'b1;
      sawValid = 1'b0;
      repeat (3*N) begin
         @(negedge clk);
         if (validA || validS || validW || validD) sawValid = 1'b1;
      end
      checkOutput("abort_noValid", sawValid, 0);
      checkOutput("abort_idleA", busyA, 0);

      // Fresh tile after the abort.
      pushTile(1, 1, 1, 1, -1, 0);
      tileConst(8'd1, 8'd1, 1);
      waitAllIdle("fresh");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
